fp16_to_int16: RTL and testbench
================================

// Module: fp16_to_int16
// PURPOSE
//   Converts IEEE-754 binary16 values to signed 16-bit integers, rounding toward zero.
//   Saturates out-of-range inputs and reports invalid/inexact flags.
//   Inverse of the FPU int-to-float path, which normalizes with lzd_16. This block denormalizes.
//   Two-stage valid/ready pipeline between the FPU operand bus and the integer writeback.
// PARAMETERS
//   NAN_VALUE  16'h8000  result driven for NaN inputs
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst_n      in   1   synchronous reset, active low
//   in_valid   in   1   in_data holds a valid fp16 operand
//   in_ready   out  1   block accepts in_data this cycle
//   in_data    in   16  fp16: [15]=sign, [14:10]=exp (bias 15), [9:0]=mantissa
//   out_valid  out  1   out_data/flags valid
//   out_ready  in   1   downstream accepts result this cycle
//   out_data   out  16  signed two's-complement result
//   out_inv    out  1   invalid: NaN, Inf or out-of-range; result saturated
//   out_inx    out  1   inexact: nonzero fraction bits discarded (never set with out_inv)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): s1_valid=0, s2_valid=0, out_data=0, out_inv=0, out_inx=0.
//   Reset drops any in-flight operands. No partial results are emitted after reset.
//   Pipeline enable: en = ~out_valid | out_ready. in_ready = en.
//   Transfer occurs when in_valid & in_ready.
//   When en=1, both stages advance: s1 <= input (valid = in_valid); s2 <= s1.
//   When en=0, both stages hold and outputs stay stable.
//   out_valid = s2_valid. Latency is 2 cycles from input transfer to out_valid.
//   Throughput is 1 result/cycle with no bubbles while out_ready=1.
//   Stage 1 (decode), registered:
//     - sign, e=exp, m={e!=0, mant} (11b), E=e-15 (signed 6b)
//     - Classes: ZERO/SUB (e==0), SPECIAL (e==31), SMALL (E<0), NORM.
//     - Stage 1 also registers the shift amount.
//   Stage 2 (shift/round/saturate), registered:
//     - ZERO/SUB: data=0; inx = (mant!=0).
//     - SMALL (E<0): data=0; inx=1.
//     - 0<=E<=10: mag = m >> (10-E); inx = OR of the shifted-out bits.
//     - 11<=E<=14: mag = m << (E-10); inx=0.
//     - E==15: sign=1 & mant=0 gives data=16'h8000, inv=0, inx=0 (exact -32768).
//       Otherwise overflow.
//     - Overflow or Inf: data = sign ? 16'h8000 : 16'h7FFF; inv=1; inx=0.
//     - NaN (e==31, mant!=0): data=NAN_VALUE; inv=1; inx=0.
//     - Result = sign ? -mag : mag, 16-bit.
//     - -0.0 gives 0 with no flags.
//   Register the flags with the data. Flags are meaningful only while out_valid=1.
//   Simultaneous accept and emit: a new input enters s1 in the same cycle s2 drains.
//   No combinational in_valid->out_valid path.
//   Combinational paths: out_ready->in_ready only.
// TESTING
//   1. 16'h3C00 (1.0) -> out_data=16'h0001, inv=0, inx=0, out_valid 2 cycles after accept.
//   2. 16'hC100 (-2.5) -> 16'hFFFE (-2), inx=1.
//      16'h3800 (0.5) -> 0, inx=1.
//      16'h0001 (subnormal) -> 0, inx=1.
//   3. 16'h7800 (+32768) -> 16'h7FFF, inv=1.
//      16'hF800 (-32768) -> 16'h8000, inv=0.
//      16'hFC00 (-Inf) -> 16'h8000, inv=1.
//      16'h7E00 (NaN) -> NAN_VALUE, inv=1.
//   4. Back-to-back stream 16'h4000, 16'h4200, 16'h4400 with out_ready=1
//      -> results 2, 3, 4 on consecutive cycles, in_ready stays 1.
//   5. Backpressure: hold out_ready=0 with 3 inputs offered -> 2 accepted, then in_ready=0.
//      out_data is held stable. Release out_ready -> in-order delivery, no loss or duplication.
//   6. Assert rst_n=0 with both stages full -> next cycle out_valid=0, out_data=0, flags=0.
//      The first post-reset input appears 2 cycles after its accept.

Source files
------------

// File: rtl/fp16_to_int16.sv
// rtl/fp16_to_int16.sv - fp16 to int16 converter, truncating toward zero, two-stage valid/ready pipeline
module fp16_to_int16 #(
    parameter logic [15:0] NAN_VALUE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_inv,
    output logic        out_inx
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SMALL,
        CLS_RSH,
        CLS_LSH,
        CLS_TOP,
        CLS_INF,
        CLS_NAN
    } cls_t;

    logic        en;
    logic [4:0]  in_exp;
    logic [9:0]  in_mant;
    logic [5:0]  exp_unb;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic        s1_mant_nz_q, s1_mant_nz_d;
    logic [10:0] s1_m_q, s1_m_d;
    logic [3:0]  s1_shift_q, s1_shift_d;
    cls_t        s1_cls_q, s1_cls_d;

    logic        s2_valid_q, s2_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_inv_q, out_inv_d;
    logic        out_inx_q, out_inx_d;

    logic [15:0] sat_val;
    logic [15:0] rmag;
    logic [15:0] lmag;
    logic [10:0] rmask;

    assign en        = ~s2_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;
    assign out_inx   = out_inx_q;

    assign in_exp  = in_data[14:10];
    assign in_mant = in_data[9:0];
    // Unbiased exponent as 6-bit two's complement; bit 5 set means E < 0.
    assign exp_unb = {1'b0, in_exp} - 6'd15;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_mant_nz_d = s1_mant_nz_q;
        s1_m_d       = s1_m_q;
        s1_shift_d   = s1_shift_q;
        s1_cls_d     = s1_cls_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d    = in_data[15];
                s1_mant_nz_d = (in_mant != 10'd0);
                s1_m_d       = {(in_exp != 5'd0), in_mant};
                s1_shift_d   = 4'd0;
                if (in_exp == 5'd0) begin
                    s1_cls_d = CLS_ZERO;
                end else if (in_exp == 5'd31) begin
                    s1_cls_d = (in_mant != 10'd0) ? CLS_NAN : CLS_INF;
                end else if (exp_unb[5]) begin
                    s1_cls_d = CLS_SMALL;
                end else if (exp_unb <= 6'd10) begin
                    s1_cls_d   = CLS_RSH;
                    s1_shift_d = 4'd10 - exp_unb[3:0];
                end else if (exp_unb <= 6'd14) begin
                    s1_cls_d   = CLS_LSH;
                    s1_shift_d = exp_unb[3:0] - 4'd10;
                end else begin
                    s1_cls_d = CLS_TOP;
                end
            end
        end
    end

    assign sat_val = s1_sign_q ? 16'h8000 : 16'h7FFF;
    assign rmag    = {5'd0, (s1_m_q >> s1_shift_q)};
    assign lmag    = {5'd0, s1_m_q} << s1_shift_q;
    assign rmask   = (11'd1 << s1_shift_q) - 11'd1;

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_inv_d  = out_inv_q;
        out_inx_d  = out_inx_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = 16'd0;
                out_inv_d  = 1'b0;
                out_inx_d  = 1'b0;
                unique case (s1_cls_q)
                    CLS_ZERO:  out_inx_d = s1_mant_nz_q;
                    CLS_SMALL: out_inx_d = 1'b1;
                    CLS_RSH: begin
                        out_data_d = s1_sign_q ? (~rmag + 16'd1) : rmag;
                        out_inx_d  = |(s1_m_q & rmask);
                    end
                    CLS_LSH:   out_data_d = s1_sign_q ? (~lmag + 16'd1) : lmag;
                    // Only -32768 is representable at E == 15; everything else saturates.
                    CLS_TOP: begin
                        out_data_d = sat_val;
                        out_inv_d  = ~(s1_sign_q & ~s1_mant_nz_q);
                    end
                    CLS_INF: begin
                        out_data_d = sat_val;
                        out_inv_d  = 1'b1;
                    end
                    CLS_NAN: begin
                        out_data_d = NAN_VALUE;
                        out_inv_d  = 1'b1;
                    end
                    default: out_data_d = 16'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_mant_nz_q <= 1'b0;
            s1_m_q       <= 11'd0;
            s1_shift_q   <= 4'd0;
            s1_cls_q     <= CLS_ZERO;
            s2_valid_q   <= 1'b0;
            out_data_q   <= 16'd0;
            out_inv_q    <= 1'b0;
            out_inx_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_mant_nz_q <= s1_mant_nz_d;
            s1_m_q       <= s1_m_d;
            s1_shift_q   <= s1_shift_d;
            s1_cls_q     <= s1_cls_d;
            s2_valid_q   <= s2_valid_d;
            out_data_q   <= out_data_d;
            out_inv_q    <= out_inv_d;
            out_inx_q    <= out_inx_d;
        end
    end

endmodule

// File: tb/tb_fp16_to_int16.sv
// tb/tb_fp16_to_int16.sv - randomized and directed bench for fp16_to_int16
module tb_fp16_to_int16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_inv;
    logic        out_inx;

    int tests_run = 0;
    int tests_failed = 0;

    fp16_to_int16 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .out_inx(out_inx)
    );

    always #5 clk = ~clk;

    // Reference: real value is (1.mant) * 2^(e-15); integer part by division, inexact by remainder.
    function automatic logic [17:0] ref_conv(input logic [15:0] x);
        int          e;
        int          mant;
        longint      full;
        longint      ip;
        longint      v;
        longint      dv;
        logic [15:0] d;
        logic        inv;
        logic        inx;
        e    = int'(x[14:10]);
        mant = int'(x[9:0]);
        inv  = 1'b0;
        inx  = 1'b0;
        ip   = 0;
        if (e == 31) begin
            d = (mant != 0) ? 16'h8000 : (x[15] ? 16'h8000 : 16'h7FFF);
            return {d, 1'b1, 1'b0};
        end
        if (e == 0) begin
            inx = (mant != 0);
        end else begin
            full = 1024 + mant;
            if (e >= 25) begin
                ip = full * (longint'(1) << (e - 25));
            end else begin
                dv  = longint'(1) << (25 - e);
                ip  = full / dv;
                inx = (full % dv) != 0;
            end
        end
        v = x[15] ? -ip : ip;
        if (v > 32767 || v < -32768) begin
            d   = x[15] ? 16'h8000 : 16'h7FFF;
            inv = 1'b1;
            inx = 1'b0;
        end else begin
            d = v[15:0];
        end
        return {d, inv, inx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run += 4;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h exp 0000", out_data); end
        if ({out_inv, out_inx} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got %b exp 00", {out_inv, out_inx}); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] vec [12];
        logic [17:0] exp_r;
        vec = '{16'h3C00, 16'hC100, 16'h3800, 16'h0001, 16'h7800, 16'hF800,
                16'hFC00, 16'h7E00, 16'h8000, 16'h7BFF, 16'h7400, 16'hF3FF};
        out_ready = 1'b1;
        foreach (vec[i]) begin
            exp_r    = ref_conv(vec[i]);
            in_data  = vec[i];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL dir_early_valid in=%h got %b exp 0", vec[i], out_valid); end
            tick();
            tests_run += 2;
            if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL dir_valid in=%h got %b exp 1", vec[i], out_valid); end
            if ({out_data, out_inv, out_inx} !== exp_r) begin
                tests_failed++;
                $display("FAIL dir_result in=%h got %h/%b%b exp %h/%b%b", vec[i], out_data, out_inv, out_inx,
                         exp_r[17:2], exp_r[1], exp_r[0]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] src [3];
        logic [15:0] got [$];
        int          first_cyc;
        int          last_cyc;
        src = '{16'h4000, 16'h4200, 16'h4400};
        out_ready = 1'b1;
        first_cyc = -1;
        last_cyc  = -1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_data  = src[c];
                in_valid = 1'b1;
                #1;
                tests_run++;
                if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready cyc=%0d got %b exp 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                got.push_back(out_data);
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        tests_run += 2;
        if (got.size() != 3) begin tests_failed++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
        if (last_cyc - first_cyc != 2) begin tests_failed++; $display("FAIL b2b_gap got span %0d exp 2", last_cyc - first_cyc); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            tests_run++;
            if (got[i] !== 16'(i + 2)) begin tests_failed++; $display("FAIL b2b_data idx=%0d got %h exp %h", i, got[i], 16'(i + 2)); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] src [3];
        logic [15:0] got [$];
        logic [15:0] held;
        int          idx;
        int          unstable;
        logic        acc;
        logic        seen;
        src = '{16'h4600, 16'h4700, 16'h4800};
        out_ready = 1'b0;
        idx = 0;
        unstable = 0;
        seen = 1'b0;
        held = 16'd0;
        for (int c = 0; c < 6; c++) begin
            in_data  = src[idx];
            in_valid = 1'b1;
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (out_valid) begin
                if (!seen) begin held = out_data; seen = 1'b1; end
                else if (out_data !== held) unstable++;
            end
        end
        tests_run += 4;
        if (idx != 2) begin tests_failed++; $display("FAIL bp_accepted got %0d exp 2", idx); end
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        if (!seen || held !== 16'd6) begin tests_failed++; $display("FAIL bp_held got %h exp 0006", held); end
        if (unstable != 0) begin tests_failed++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            if (idx < 3) begin in_data = src[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got.size() != 3) begin tests_failed++; $display("FAIL bp_drain_count got %0d exp 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            tests_run++;
            if (got[i] !== 16'(i + 6)) begin tests_failed++; $display("FAIL bp_order idx=%0d got %h exp %h", i, got[i], 16'(i + 6)); end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC100;
        tick();
        in_data   = 16'h7800;
        tick();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        tick();
        tests_run += 3;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0000) begin tests_failed++; $display("FAIL rst_mid_data got %h exp 0000", out_data); end
        if ({out_inv, out_inx} !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_flags got %b exp 00", {out_inv, out_inx}); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ghost got %b exp 0", out_valid); end
        in_data  = 16'h4500;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_early got %b exp 0", out_valid); end
        tick();
        tests_run++;
        if (!(out_valid === 1'b1 && out_data === 16'd5 && out_inv === 1'b0 && out_inx === 1'b0)) begin
            tests_failed++;
            $display("FAIL rst_mid_first got v=%b %h/%b%b exp v=1 0005/00", out_valid, out_data, out_inv, out_inx);
        end
        tick();
    endtask

    task automatic test_random();
        logic [17:0] q [$];
        logic [17:0] exp_r;
        int          n_items;
        int          sent;
        int          got;
        logic        acc;
        logic [4:0]  e;
        n_items = 400;
        sent = 0;
        got  = 0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 5000 && got < n_items; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < n_items && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    e = 5'($urandom_range(13, 31));
                    in_data = {1'($urandom), e, 10'($urandom)};
                end else begin
                    in_data = 16'($urandom);
                end
                in_valid = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_spurious got %h exp none", out_data);
                end else begin
                    exp_r = q.pop_front();
                    if ({out_data, out_inv, out_inx} !== exp_r) begin
                        tests_failed++;
                        $display("FAIL rnd_result idx=%0d got %h/%b%b exp %h/%b%b", got, out_data, out_inv, out_inx,
                                 exp_r[17:2], exp_r[1], exp_r[0]);
                    end
                end
                got++;
            end
            if (acc) begin
                q.push_back(ref_conv(in_data));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        tests_run += 2;
        if (got != n_items) begin tests_failed++; $display("FAIL rnd_count got %0d exp %0d", got, n_items); end
        if (q.size() != 0) begin tests_failed++; $display("FAIL rnd_leftover got %0d exp 0", q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
